// File: rtl/sort_pkg.sv
// Shared definitions for the odd-even transposition sort slice.
//
// Holds the default batch geometry (shared with the register array so both
// sides agree on N and W) and the sequencer state encoding.
package sort_pkg;

  // Default number of words per sort batch. Must be even and >= 2.
  localparam int unsigned SortN = 8;

  // Default word width in bits.
  localparam int unsigned SortW = 4;

  // Sequencer states:
  //   StLoad   - accepting words from the input stream into the array
  //   StSort   - driving N alternating even/odd compare-swap phases
  //   StUnload - reading the sorted array out on the output stream
  typedef enum logic [1:0] {
    StLoad   = 2'd0,
    StSort   = 2'd1,
    StUnload = 2'd2
  } sort_state_e;

endpackage

// File: rtl/mod_counter.sv
// Saturating up-counter with explicit clear, used for the write, phase and
// read indices of the sort sequencer.
//
// Parameters:
//   Max    - terminal count; the counter never exceeds this value.
//   Width  - counter width in bits.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-low reset, forces cnt to 0
//   clr    in   return cnt to 0 at the next edge (wins over inc)
//   inc    in   advance cnt by one at the next edge
//   cnt    out  current count
//   last   out  cnt == Max
module mod_counter #(
  parameter int unsigned Max   = 7,
  parameter int unsigned Width = (Max > 0) ? $clog2(Max + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] cnt,
  output logic             last
);

  logic [Width-1:0] cnt_q;
  logic [Width-1:0] cnt_d;

  assign last = (cnt_q == Width'(Max));
  assign cnt  = cnt_q;

  // Saturate at Max rather than wrapping; the owner clears explicitly when
  // it leaves the state that uses the counter.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !last) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sort_sequencer.sv
// Control and stream-interface stage for an odd-even transposition register
// array. A batch of N words is accepted over a valid/ready input stream and
// written into the array, the array is then driven through N alternating
// even/odd compare-swap phases, and the sorted words are read back and sent
// out in ascending index order on a valid/ready output stream.
//
// N must be even and at least 2; CW is derived from N and cannot be
// overridden.
//
// Ports:
//   clk        in   clock, all state on the rising edge
//   reset      in   synchronous active-low reset; aborts any batch
//   in_data    in   input word
//   in_valid   in   input word valid
//   in_ready   out  sequencer accepts a word this cycle
//   ld_en      out  array write strobe (combinational with the accept)
//   ld_idx     out  array write index
//   ld_data    out  array write data
//   even       out  even-phase compare-swap enable
//   odd        out  odd-phase compare-swap enable
//   rd_idx     out  array read index
//   rd_data    in   array word at rd_idx, combinational read
//   out_data   out  output word
//   out_valid  out  output word valid
//   out_ready  in   downstream accepts the output word
//   busy       out  high while sorting or unloading
//   done       out  one-cycle pulse after the last output handshake
module sort_sequencer
  import sort_pkg::*;
#(
  parameter  int unsigned N  = SortN,
  parameter  int unsigned W  = SortW,
  localparam int unsigned CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  // input stream
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  // array load port
  output logic          ld_en,
  output logic [CW-1:0] ld_idx,
  output logic [W-1:0]  ld_data,
  // array phase controls
  output logic          even,
  output logic          odd,
  // array read port
  output logic [CW-1:0] rd_idx,
  input  logic [W-1:0]  rd_data,
  // output stream
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  // status
  output logic          busy,
  output logic          done
);

  sort_state_e state_q;

  // Registered status/handshake outputs, updated together with the state.
  logic in_ready_q;
  logic out_valid_q;
  logic even_q;
  logic odd_q;
  logic busy_q;
  logic done_q;

  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] ph_cnt;
  logic [CW-1:0] rd_cnt;
  logic          wr_last;
  logic          ph_last;
  logic          rd_last;

  logic accept;
  logic out_hs;
  logic sorting;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------

  // Masking with reset keeps a reset cycle from looking like a handshake on
  // either stream, so nothing is written to the array or consumed downstream
  // while the batch is being abandoned.
  assign in_ready  = in_ready_q & reset;
  assign out_valid = out_valid_q & reset;

  assign accept  = (state_q == StLoad) & in_valid & in_ready;
  assign out_hs  = out_valid & out_ready;
  assign sorting = (state_q == StSort);

  // ---------------------------------------------------------------------------
  // Index counters
  // ---------------------------------------------------------------------------

  mod_counter #(
    .Max   (N - 1),
    .Width (CW)
  ) u_wr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept & wr_last),
    .inc   (accept),
    .cnt   (wr_cnt),
    .last  (wr_last)
  );

  mod_counter #(
    .Max   (N - 1),
    .Width (CW)
  ) u_ph_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (sorting & ph_last),
    .inc   (sorting),
    .cnt   (ph_cnt),
    .last  (ph_last)
  );

  mod_counter #(
    .Max   (N - 1),
    .Width (CW)
  ) u_rd_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (out_hs & rd_last),
    .inc   (out_hs),
    .cnt   (rd_cnt),
    .last  (rd_last)
  );

  // ---------------------------------------------------------------------------
  // Array and output-stream datapath
  // ---------------------------------------------------------------------------

  // Idle ports are driven to zero rather than left floating.
  assign ld_en    = accept;
  assign ld_idx   = accept ? wr_cnt : '0;
  assign ld_data  = accept ? in_data : '0;
  assign rd_idx   = (state_q == StUnload) ? rd_cnt : '0;
  assign out_data = out_valid ? rd_data : '0;

  assign even = even_q;
  assign odd  = odd_q;
  assign busy = busy_q;
  assign done = done_q;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StLoad;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      even_q      <= 1'b0;
      odd_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (accept && wr_last) begin
            state_q    <= StSort;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            // Phase 0 is an even phase.
            even_q     <= 1'b1;
            odd_q      <= 1'b0;
          end
        end
        StSort: begin
          if (ph_last) begin
            state_q     <= StUnload;
            even_q      <= 1'b0;
            odd_q       <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            // Next phase is ph_cnt+1: even when the current phase is odd.
            even_q <= ph_cnt[0];
            odd_q  <= ~ph_cnt[0];
          end
        end
        StUnload: begin
          if (out_hs && rd_last) begin
            state_q     <= StLoad;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            // Ready again in the done cycle so batches can run back to back.
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StLoad;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          even_q      <= 1'b0;
          odd_q       <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// Self-checking bench for sort_sequencer with a behavioural register array.
module tb_sort_sequencer;
  import sort_pkg::*;

  localparam int unsigned N  = SortN;
  localparam int unsigned W  = SortW;
  localparam int unsigned CW = $clog2(N);

  typedef logic [W-1:0] word_t;

  logic          clk = 1'b0;
  logic          reset;
  word_t         in_data;
  logic          in_valid;
  logic          in_ready;
  logic          ld_en;
  logic [CW-1:0] ld_idx;
  word_t         ld_data;
  logic          even;
  logic          odd;
  logic [CW-1:0] rd_idx;
  word_t         rd_data;
  word_t         out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  word_t exp_q[$];

  // out_ready control
  bit rdy_random = 1'b0;
  int stall_left = 0;
  int stall_idx  = 0;

  always #5 clk = ~clk;

  sort_sequencer #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ld_en     (ld_en),
    .ld_idx    (ld_idx),
    .ld_data   (ld_data),
    .even      (even),
    .odd       (odd),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // Behavioural odd-even transposition array.
  word_t arr [N];

  always @(posedge clk) begin
    if (ld_en) arr[ld_idx] <= ld_data;
    if (even || odd) begin
      for (int k = (even ? 0 : 1); k + 1 < int'(N); k += 2) begin
        if (arr[k] > arr[k+1]) begin
          arr[k]   <= arr[k+1];
          arr[k+1] <= arr[k];
        end
      end
    end
  end

  assign rd_data = arr[rd_idx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Feeds words until `count` have been accepted; a full batch pushes its
  // sorted contents into the scoreboard.
  task automatic send_batch(input word_t w[N], input int vmode, input int count,
                            input bit keep);
    int    i   = 0;
    int    cyc = 0;
    bit    acc;
    word_t q[$];
    while (i < count) begin
      in_data = w[i];
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      cyc++;
      if (cyc > 2000) begin
        chk("send_timeout", 32'(i), 32'(count));
        break;
      end
    end
    if (!keep) in_valid = 1'b0;
    if (i == int'(N)) begin
      for (int k = 0; k < int'(N); k++) q.push_back(w[k]);
      q.sort();
      foreach (q[k]) exp_q.push_back(q[k]);
    end
  endtask

  task automatic pulse_reset(input int cycles);
    reset = 1'b0;
    exp_q.delete();
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_batch(output word_t w[N]);
    for (int k = 0; k < int'(N); k++) w[k] = word_t'($urandom_range(0, (1 << W) - 1));
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && out_valid && int'(rd_idx) == stall_idx) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rdy_random) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: protocol model from the batch rules plus scoreboard pop.
  // m_mode: 0 loading, 1 sorting, 2 unloading; m_cnt counts within the mode.
  initial begin
    int    m_mode = 0;
    int    m_cnt  = 0;
    bit    m_done = 1'b0;
    bit    m_ok   = 1'b0;
    bit    p_stall = 1'b0;
    word_t p_data = '0;
    word_t exp_w;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("ld_en_in_reset", 32'(ld_en), 32'd0);
        m_mode  = 0;
        m_cnt   = 0;
        m_done  = 1'b0;
        m_ok    = 1'b1;
        p_stall = 1'b0;
      end else if (m_ok) begin
        chk("in_ready", 32'(in_ready), 32'(m_mode == 0));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("even", 32'(even), 32'(m_mode == 1 && m_cnt % 2 == 0));
        chk("odd", 32'(odd), 32'(m_mode == 1 && m_cnt % 2 == 1));
        chk("out_valid", 32'(out_valid), 32'(m_mode == 2));
        chk("done", 32'(done), 32'(m_done));
        chk("ld_en", 32'(ld_en), 32'(m_mode == 0 && in_valid));
        if (ld_en) begin
          chk("ld_idx", 32'(ld_idx), 32'(m_cnt));
          chk("ld_data", 32'(ld_data), 32'(in_data));
        end
        if (m_mode == 2) chk("rd_idx", 32'(rd_idx), 32'(m_cnt));
        if (p_stall) chk("hold_data", 32'(out_data), 32'(p_data));
        p_stall = 1'b0;
        m_done  = 1'b0;
        case (m_mode)
          0: begin
            if (in_valid) begin
              m_cnt++;
              if (m_cnt == int'(N)) begin
                m_mode = 1;
                m_cnt  = 0;
              end
            end
          end
          1: begin
            m_cnt++;
            if (m_cnt == int'(N)) begin
              m_mode = 2;
              m_cnt  = 0;
            end
          end
          default: begin
            if (out_ready) begin
              if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
              end else begin
                exp_w = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(exp_w));
              end
              m_cnt++;
              if (m_cnt == int'(N)) begin
                m_mode = 0;
                m_cnt  = 0;
                m_done = 1'b1;
              end
            end else begin
              p_stall = 1'b1;
              p_data  = out_data;
            end
          end
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t b [N];
    word_t b2[N];
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    pulse_reset(2);

    // 1: fixed batch, in_valid held high
    b = '{4'd3, 4'd0, 4'd15, 4'd0, 4'd12, 4'd0, 4'd0, 4'd0};
    send_batch(b, 0, N, 1'b0);
    drain();

    // 2: reverse order, in_valid toggling
    b = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
    send_batch(b, 1, N, 1'b0);
    drain();

    // 3: downstream stall on word 2
    stall_idx  = 2;
    stall_left = 3;
    rand_batch(b);
    send_batch(b, 0, N, 1'b0);
    drain();
    stall_left = 0;

    // 4: reset during SORT phase 3, then a batch of fives
    rand_batch(b);
    send_batch(b, 0, N, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    pulse_reset(1);
    b = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
    send_batch(b, 0, N, 1'b0);
    drain();

    // 5: back-to-back batches with in_valid held through done
    rand_batch(b);
    rand_batch(b2);
    send_batch(b, 0, N, 1'b1);
    send_batch(b2, 0, N, 1'b0);
    drain();

    // 6: reset while in_valid is high in the middle of a load
    rand_batch(b);
    send_batch(b, 0, 3, 1'b1);
    pulse_reset(1);
    rand_batch(b);
    send_batch(b, 0, N, 1'b0);
    drain();

    // random traffic on both streams
    rdy_random = 1'b1;
    for (int r = 0; r < 4; r++) begin
      rand_batch(b);
      send_batch(b, 2, N, 1'b0);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
